seq_divider: RTL and testbench

Iterative unsigned restoring divider: divides a 16-bit dividend by an 8-bit divisor, producing a 16-bit quotient and 8-bit remainder. It is the inverse companion of the combinational 8x8 multiplier: feeding it a product `x` and one factor recovers the other factor with zero remainder. It sits beside the multiplier in the arithmetic datapath. It trades area for latency by retiring one quotient bit per clock behind a start/done handshake.

---
 rtl/seq_divider.sv | 143 ++++++++++++++
 tb/tb_seq_divider.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: XW-bit dividend / BW-bit divisor, one quotient bit per clock.
// Optional SEQ_DIVIDER_ZERO_SHORTCUT_EN finishes a divide-by-zero one edge after acceptance.
module seq_divider #(
    parameter int XW = 16,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] a,
    input  logic [BW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] q,
    output logic [BW-1:0] r,
    output logic          dz
);

    localparam int CNT_W = (XW > 2) ? $clog2(XW) : 1;

    generate
        if (BW > XW || XW < 2) begin : g_bad_params
            $error("seq_divider: requires 2 <= XW and BW <= XW");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [XW-1:0] acc_p0;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [BW:0]   rem_p0;
    logic [BW-1:0] div_p0;
    logic [BW-1:0] a_lo_p0;

    logic [BW+1:0] step;
    logic          q_bit;
    logic [BW:0]   rem_nxt;
    logic [XW-1:0] acc_nxt;
    logic          last_step;
    logic          div_zero;
    logic          finish;
    logic [XW+BW:0] result;

    // One restoring step; returns {quotient bit, new partial remainder}.
    function automatic logic [BW+1:0] restore_step(
        input logic [BW:0]   rem,
        input logic          msb,
        input logic [BW-1:0] div
    );
        logic [BW:0]   shifted;
        logic [BW+1:0] diff;
        shifted = {rem[BW-1:0], msb};
        diff    = {1'b0, shifted} - {2'b00, div};
        if (diff[BW+1])
            return {1'b0, shifted};
        else
            return {1'b1, diff[BW:0]};
    endfunction

    // Packs {dz, q, r}; a zero divisor forces the defined result regardless of the datapath.
    function automatic logic [XW+BW:0] final_result(
        input logic          zero,
        input logic [XW-1:0] quot,
        input logic [BW-1:0] rem_lo,
        input logic [BW-1:0] dividend_lo
    );
        if (zero)
            return {1'b1, {XW{1'b1}}, dividend_lo};
        else
            return {1'b0, quot, rem_lo};
    endfunction

    assign step               = restore_step(rem_p0, acc_p0[XW-1], div_p0);
    assign {q_bit, rem_nxt}   = step;
    assign acc_nxt            = {acc_p0[XW-2:0], q_bit};
    assign last_step          = (cnt == CNT_W'(XW - 1));
    assign div_zero           = (div_p0 == '0);
    assign result             = final_result(div_zero, acc_nxt, rem_nxt[BW-1:0], a_lo_p0);

`ifdef SEQ_DIVIDER_ZERO_SHORTCUT_EN
    assign finish = last_step || div_zero;
`else
    assign finish = last_step;
`endif

    // Stage p0: operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            acc_p0  <= a;
            div_p0  <= b;
            a_lo_p0 <= a[BW-1:0];
            rem_p0  <= '0;
        end else if (state == RUN) begin
            acc_p0 <= acc_nxt;
            rem_p0 <= rem_nxt;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        cnt          <= '0;
                        {dz, q, r}   <= result;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed and random operations against an arithmetic reference model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SEQ_DIVIDER_ZERO_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    seq_divider #(.XW(16), .BW(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .q    (q),
        .r    (r),
        .dz   (dz)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division with the divide-by-zero rule.
    function automatic logic [24:0] ref_div(input logic [15:0] x, input logic [7:0] y);
        if (y == 8'd0)
            return {1'b1, 16'hFFFF, x[7:0]};
        else
            return {1'b0, x / {8'd0, y}, 8'(x % {8'd0, y})};
    endfunction

    function automatic int ref_lat(input logic [7:0] y);
        return (SHORTCUT && y == 8'd0) ? 1 : 16;
    endfunction

    task automatic launch(input logic [15:0] ta, input logic [7:0] tb);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 8'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #22;
        n_checks++;
        if ({busy, done, q, r, dz} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_values: got busy=%b done=%b q=%h r=%h dz=%b, want all 0", busy, done, q, r, dz);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] va [9] = '{16'h3039, 16'hFB06, 16'hFFFF, 16'h0005, 16'h00FF,
                                16'h1234, 16'h0077, 16'h0000, 16'hABCD};
        logic [7:0]  vb [9] = '{8'h7B, 8'hFD, 8'h01, 8'h07, 8'hFF,
                                8'h00, 8'h02, 8'h05, 8'h00};
        logic [24:0] exp;
        logic [15:0] q_hold;
        int          lat;
        for (int i = 0; i < 9; i++) begin
            exp = ref_div(va[i], vb[i]);
            launch(va[i], vb[i]);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_after_start[%0d]: got %b, want 1", i, busy);
            end
            wait_done(lat);
            n_checks++;
            if (lat != ref_lat(vb[i])) begin
                n_fail++;
                $display("FAIL latency[%0d] a=%h b=%h: got %0d edges, want %0d", i, va[i], vb[i], lat, ref_lat(vb[i]));
            end
            n_checks++;
            if ({dz, q, r} !== exp || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL result[%0d] a=%h b=%h: got q=%h r=%h dz=%b busy=%b, want q=%h r=%h dz=%b busy=0",
                         i, va[i], vb[i], q, r, dz, busy, exp[23:8], exp[7:0], exp[24]);
            end
            q_hold = q;
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || q !== exp[23:8] || dz !== exp[24]) begin
                n_fail++;
                $display("FAIL done_pulse_hold[%0d]: got done=%b q=%h dz=%b, want done=0 q=%h dz=%b",
                         i, done, q, dz, q_hold, exp[24]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] ta;
        logic [7:0]  tb;
        logic [24:0] exp;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            tb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            ta = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            exp = ref_div(ta, tb);
            launch(ta, tb);
            wait_done(lat);
            n_checks++;
            if (lat != ref_lat(tb) || {dz, q, r} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                         i, ta, tb, q, r, dz, lat, exp[23:8], exp[7:0], exp[24], ref_lat(tb));
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [24:0] exp;
        int          lat;
        exp = ref_div(16'h4E20, 8'h64);
        launch(16'h4E20, 8'h64);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        a     = 16'h0100;
        b     = 8'h03;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        n_checks++;
        if (lat != 11 || {dz, q, r} !== exp) begin
            n_fail++;
            $display("FAIL ignore_start: got q=%h r=%h dz=%b done_edge=%0d, want q=%h r=%h dz=0 done_edge=16",
                     q, r, dz, (lat < 0) ? -1 : lat + 5, exp[23:8], exp[7:0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_no_queue: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [24:0] exp1, exp2;
        int          lat1, lat2;
        exp1 = ref_div(16'hC350, 8'hC8);
        exp2 = ref_div(16'h0FA1, 8'h11);
        start = 1'b1;
        a     = 16'hC350;
        b     = 8'hC8;
        @(posedge clk); #1;
        a = 16'h0FA1;
        b = 8'h11;
        wait_done(lat1);
        n_checks++;
        if (lat1 != 16 || {dz, q, r} !== exp1) begin
            n_fail++;
            $display("FAIL b2b_first: got q=%h r=%h lat=%0d, want q=%h r=%h lat=16", q, r, lat1, exp1[23:8], exp1[7:0]);
        end
        @(posedge clk); #1;
        start = 1'b0;
        a     = 16'($urandom);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        wait_done(lat2);
        if (lat2 > 0) lat2 = lat2 + 1;
        n_checks++;
        if (lat2 != 17 || {dz, q, r} !== exp2) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%h r=%h gap=%0d, want q=%h r=%h gap=17", q, r, lat2, exp2[23:8], exp2[7:0]);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [24:0] exp;
        int          pulses;
        int          lat;
        launch(16'h9999, 8'h07);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, q, r, dz} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b q=%h r=%h dz=%b, want all 0", busy, done, q, r, dz);
        end
        @(posedge clk); @(posedge clk); #1;
        rst    = 1'b0;
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        n_checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abandon: got %0d done pulses busy=%b, want 0 pulses busy=0", pulses, busy);
        end
        exp = ref_div(16'h0064, 8'h0A);
        launch(16'h0064, 8'h0A);
        wait_done(lat);
        n_checks++;
        if (lat != 16 || {dz, q, r} !== exp) begin
            n_fail++;
            $display("FAIL after_reset_op: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=0 lat=16",
                     q, r, dz, lat, exp[23:8], exp[7:0]);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
